// File: rtl/interrupt_request_controller.sv
// Interrupt request controller: rising-edge capture into a pending register, mask and
// global enable, fixed lowest-index priority, and a non-nesting request/service handshake.
module interrupt_request_controller #(
    parameter int unsigned IRQ_COUNT          = 8,
    parameter logic [31:0] VECTOR_BASE        = 32'h0000_0100,
    parameter int unsigned VECTOR_STRIDE_LOG2 = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [IRQ_COUNT-1:0]         irq,
    input  logic                         maskWrite,
    input  logic [IRQ_COUNT-1:0]         maskData,
    input  logic                         globalEnable,
    input  logic                         interruptAck,
    input  logic                         iretDone,
    output logic                         interruptPending,
    output logic [31:0]                  isrAddress,
    output logic [$clog2(IRQ_COUNT)-1:0] activeIrq,
    output logic                         inService,
    output logic [IRQ_COUNT-1:0]         pendingStatus
);

    localparam int unsigned IDX_W = $clog2(IRQ_COUNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t               state, state_n;
    logic                 pend_n;
    logic                 insvc_n;
    logic [IDX_W-1:0]     act_n;
    logic [31:0]          addr_n;

    logic [IRQ_COUNT-1:0] irq_prev;
    logic [IRQ_COUNT-1:0] mask;
    logic [IRQ_COUNT-1:0] irq_rise;
    logic [IRQ_COUNT-1:0] eligible;
    logic [IRQ_COUNT-1:0] pending_clr;
    logic [IDX_W-1:0]     winner;
    logic                 ack_take;

    assign irq_rise = irq & ~irq_prev;
    assign eligible = pendingStatus & mask;
    assign ack_take = enable && (state == REQUEST) && interruptAck;

    // Lowest set index wins: scan downwards so the last hit is the lowest.
    always_comb begin
        winner = '0;
        for (int i = int'(IRQ_COUNT) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = IDX_W'(i);
            end
        end
    end

    always_comb begin
        pending_clr = '0;
        if (ack_take) begin
            pending_clr[activeIrq] = 1'b1;
        end
    end

    // Edge capture and mask run regardless of enable; a new edge beats a same-cycle clear.
    always_ff @(posedge clk) begin
        irq_prev <= irq;
        if (reset) begin
            pendingStatus <= '0;
            mask          <= '0;
        end else begin
            pendingStatus <= (pendingStatus & ~pending_clr) | irq_rise;
            if (maskWrite) begin
                mask <= maskData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            interruptPending <= 1'b0;
            inService        <= 1'b0;
            activeIrq        <= '0;
            isrAddress       <= VECTOR_BASE;
        end else begin
            state            <= state_n;
            interruptPending <= pend_n;
            inService        <= insvc_n;
            activeIrq        <= act_n;
            isrAddress       <= addr_n;
        end
    end

    always_comb begin
        state_n = state;
        pend_n  = interruptPending;
        insvc_n = inService;
        act_n   = activeIrq;
        addr_n  = isrAddress;
        if (enable) begin
            unique case (state)
                IDLE: begin
                    if (globalEnable && (|eligible)) begin
                        state_n = REQUEST;
                        pend_n  = 1'b1;
                        act_n   = winner;
                        addr_n  = VECTOR_BASE + (32'(winner) << VECTOR_STRIDE_LOG2);
                    end
                end
                // Winner is frozen here; only ack or loss of global enable leaves.
                REQUEST: begin
                    if (interruptAck) begin
                        state_n = SERVICE;
                        pend_n  = 1'b0;
                        insvc_n = 1'b1;
                    end else if (!globalEnable) begin
                        state_n = IDLE;
                        pend_n  = 1'b0;
                    end
                end
                SERVICE: begin
                    if (iretDone) begin
                        state_n = IDLE;
                        insvc_n = 1'b0;
                    end
                end
                default: begin
                    state_n = IDLE;
                    pend_n  = 1'b0;
                    insvc_n = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/interrupt_request_controller.md
Name: interrupt_request_controller

Overview:
Collects external interrupt request lines and latches them as pending. Applies a software mask and a global enable, and selects one winner by fixed priority. Presents interruptPending and the ISR vector address to the CPU controller, which the controller consumes in its INTERRUPT state. Tracks in-service status until the return-from-interrupt retires, with no nesting.

Parameters:
IRQ_COUNT, 8, number of request lines (2..32)
VECTOR_BASE, 32'h0000_0100, ISR address of irq 0
VECTOR_STRIDE_LOG2, 4, log2 byte spacing between vectors

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  pipeline stall; low = FSM/outputs hold
irq  in  IRQ_COUNT  request lines, synchronous to clk, rising-edge triggered
maskWrite  in  1  load mask register from maskData
maskData  in  IRQ_COUNT  new mask, 1 = line enabled
globalEnable  in  1  interrupt-enable flag from flags register
interruptAck  in  1  controller entered INTERRUPT state, vector taken
iretDone  in  1  IRET retired, service finished
interruptPending  out  1  request to controller
isrAddress  out  32  vector for LOAD_ISR
activeIrq  out  $clog2(IRQ_COUNT)  index of selected/serviced line
inService  out  1  handler running
pendingStatus  out  IRQ_COUNT  raw pending register

Behaviour:
- Single clock. Reset is synchronous and active-high.
- Reset: pending=0, mask=0 (all masked), state=IDLE. Outputs: interruptPending=0, inService=0, activeIrq=0, isrAddress=VECTOR_BASE, pendingStatus=0. irqPrev loads the current irq value, so a line already high at reset release creates no edge.
- Edge capture runs every cycle, independent of enable:
  - irqPrev <= irq.
  - pending[i] is set when irq[i]=1 and irqPrev[i]=0.
  - A set and a clear of the same bit in the same cycle: set wins.
- Mask: on maskWrite, mask <= maskData at the clock edge. The old mask is used for selection in that cycle. Mask writes are accepted regardless of enable.
- Eligible = pending & mask. Winner = lowest set index of eligible.
- All FSM transitions and outputs below require enable=1; otherwise state, activeIrq, isrAddress, interruptPending and inService hold. interruptAck and iretDone are ignored while enable=0.
- FSM states: IDLE, REQUEST, SERVICE.
  - IDLE:
    - Condition: globalEnable=1 and eligible != 0.
    - Action: go to REQUEST, activeIrq <= winner, isrAddress <= VECTOR_BASE + (winner << VECTOR_STRIDE_LOG2), mod 2^32.
    - interruptPending=1 from the next cycle.
  - REQUEST:
    - The winner is frozen. Later higher-priority edges do not preempt it.
    - interruptAck=1: go to SERVICE, clear pending[activeIrq], interruptPending=0, inService=1.
    - Else if globalEnable=0: go to IDLE, interruptPending=0, pending untouched.
    - Ack and globalEnable=0 in the same cycle: ack wins.
    - The winner becoming masked while in REQUEST does not withdraw the request.
  - SERVICE:
    - No new request is raised.
    - iretDone=1: go to IDLE, inService=0. A new selection is possible the following cycle; back-to-back service is allowed.
    - Spurious interruptAck is ignored.
- Latency: irq rising at sample edge k sets pending after edge k, and interruptPending goes high after edge k+1 (2 cycles).
- interruptAck or iretDone in IDLE: ignored.
- Reset mid-operation returns to the reset values immediately, with no service completion.

Test Plan:
- Reset, then mask=8'hFF, globalEnable=1, irq[3] rises at edge k -> pendingStatus=8'h08 after k; interruptPending=1, activeIrq=3, isrAddress=32'h0000_0130 after k+1.
- irq[5] and irq[2] rise in the same cycle -> irq 2 selected (isrAddress 32'h0000_0120). Ack -> pendingStatus=8'h20, inService=1. iretDone -> IDLE, then irq 5 is requested 1 cycle later (32'h0000_0150).
- Request raised, then enable=0 for 4 cycles with interruptAck asserted -> state and outputs hold, no ack taken. enable=1 with ack -> SERVICE.
- mask=8'h00, irq[1] rises -> pendingStatus=8'h02, no request. Write mask=8'h02 -> interruptPending=1 two cycles after maskWrite.
- In REQUEST, drop globalEnable with no ack -> interruptPending=0, pending bit kept. Same drop coincident with ack -> SERVICE entered.
- During SERVICE of irq 0, irq[0] rises again in the same cycle as its clear -> pending[0] remains 1. Hold irq high through reset release -> no pending bit set.
